ws2812b_rx_decoder: RTL and testbench
=====================================

# ws2812b_rx_decoder

Front-end stage of the WS2812B receive path: it synchronises the raw serial line, measures each high pulse to classify it as a 0 or 1 code, and assembles the bits MSB-first into bytes. It detects the WS2812B reset/latch gap and reports it as an idle event. Its `bit_valid`/`bit_value`/`byte_valid`/`idle` outputs feed the demux/forwarding stage directly downstream, which also receives the same `din_raw` line for pass-through.

## Interface
- `BIT_THRESH`, default 38: high-time threshold in clk cycles. H ≥ BIT_THRESH gives bit 1, otherwise bit 0 (38 cycles ≈ 0.6 µs at 64 MHz).
- `IDLE_CYCLES`, default 3200: continuous low time, in clk cycles, that constitutes a reset gap (50 µs at 64 MHz).
- `MIN_PULSE`, default 6: minimum valid high time in cycles; used only when the glitch filter is compiled in.
- `CNT_W`, default 12: width of the pulse counter. Requires IDLE_CYCLES < 2^CNT_W and BIT_THRESH < 2^CNT_W.
- `clk` input 1: the only clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `din_raw` input 1: asynchronous WS2812B serial line.
- `bit_valid` output 1: one-cycle pulse per decoded bit.
- `bit_value` output 1: the decoded bit; valid while `bit_valid` is high, holds its value otherwise.
- `byte_valid` output 1: one-cycle pulse when the 8th bit of a byte is decoded.
- `byte_data` output 8: last completed byte, MSB first on the wire; holds until the next `byte_valid`.
- `idle` output 1: one-cycle pulse when the low time reaches IDLE_CYCLES.
- `glitch` output 1: one-cycle pulse when a runt pulse is discarded; tied to 0 without the macro.

## Operation
- `din_raw` passes through a 2-flop synchroniser to give `din_s`. Rising and falling edges are detected against a registered copy of `din_s`.
- Pulse counter `cnt`: CNT_W bits, saturating at 2^CNT_W−1, never wraps. Bit counter `bit_cnt`: 3 bits. Shift register `sr`: 8 bits.
- FSM states:
  - S_IDLE (reset state): line in gap. On a rising edge, set cnt=1 and go to S_HIGH.
  - S_HIGH: increment cnt each cycle the line stays high. On a falling edge, H = cnt:
    - Emit `bit_valid`=1 and `bit_value`=(H≥BIT_THRESH).
    - Update `sr` = {sr[6:0], bit_value} and increment `bit_cnt`.
    - If bit_cnt was 7: `byte_valid`=1, `byte_data`={sr[6:0], bit_value}, bit_cnt wraps to 0.
    - Set cnt=1 and go to S_LOW.
  - S_LOW: increment cnt each low cycle.
    - On a rising edge: set cnt=1 and go to S_HIGH.
    - When cnt reaches IDLE_CYCLES: `idle`=1 for one cycle, clear bit_cnt and sr, go to S_IDLE.
- A partial byte at the time of idle is discarded; no `byte_valid` is generated for it.
- A line stuck high saturates cnt; the eventual falling edge decodes as bit 1.
- `idle` fires only after a low period that follows at least one high pulse. There is no idle pulse out of reset.
- Reset mid-operation: all outputs go to 0, `byte_data`=0x00, state S_IDLE. The first edge after release starts a fresh byte.

## Timing
- Reset values: `bit_valid`, `bit_value`, `byte_valid`, `idle` and `glitch` are 0; `byte_data` is 0x00.
- Latency: all outputs are registered. `bit_valid`/`byte_valid` assert in the cycle after the 3rd rising clk edge following a `din_raw` falling edge (2 synchroniser stages + 1 output register). `idle` uses the same pipeline alignment.
- `byte_valid` coincides with the 8th `bit_valid` of the byte.
- Minimum spacing between `bit_valid` pulses is 2 cycles; downstream must accept every pulse, there is no back-pressure.
- The decoder tolerates the WS2812B ±150 ns timing window at clk ≥ 20 MHz with suitably scaled parameters.

## Configuration
- `WS2812B_GLITCH_FILTER_EN` defined:
  - In S_HIGH, a falling edge with H < MIN_PULSE is a runt. It produces no `bit_valid`, leaves bit_cnt and sr unchanged, and pulses `glitch` for one cycle.
  - After a runt, the FSM goes to S_LOW with cnt=1, so the idle timing restarts.
- Not defined: every high pulse, of any length, is decoded as a bit; `glitch` is constant 0.

## Test plan
- Byte decode: drive 0xA5 as 8 pulses (H=26 for 0, H=51 for 1, 80-cycle bit period) → bit_valid ×8 with values 1,0,1,0,0,1,0,1; a single byte_valid with byte_data=0xA5, coincident with the 8th bit.
- Threshold boundary: H=37 gives bit_value 0; H=38 gives bit_value 1.
- Frame + gap: send 24 bits (0x12,0x34,0x56) then hold the line low → 3 byte_valid pulses; idle pulses exactly once, IDLE_CYCLES low cycles after the last falling edge (± the fixed pipeline offset); no idle after reset alone.
- Partial byte: 5 bits, then a 3200-cycle low, then 0xC3 → no byte_valid for the fragment; the next byte_valid carries byte_data=0xC3.
- Reset mid-byte: assert reset after 4 bits → outputs 0 immediately (asynchronous); after release, 0xFF decodes correctly with 8 bits.
- Glitch filter (macro on): a 3-cycle pulse between bits 2 and 3 of 0x0F → glitch=1 once, byte_data=0x0F. Macro off: the same stimulus gives 9 bit_valid pulses.

Source files
------------

// File: rtl/ws2812b_rx_decoder_if.sv
// ws2812b_rx_decoder_if
// Bundles the serial line and the decoded-event outputs of the WS2812B
// receive front-end.
//   din_raw    : asynchronous WS2812B serial line (also forwarded downstream)
//   bit_valid  : one-cycle pulse per decoded bit
//   bit_value  : decoded bit, valid with bit_valid, held otherwise
//   byte_valid : one-cycle pulse with the 8th bit of a byte
//   byte_data  : last completed byte, held until the next byte_valid
//   idle       : one-cycle pulse when a reset/latch gap is seen
//   glitch     : one-cycle pulse when a runt pulse is dropped
//   state_dbg  : current decoder FSM state (debug visibility)
// Event semantics: every output is a registered pulse or held value; there is
// no ready/back-pressure, so the consumer must accept each pulse in the cycle
// it is presented.
interface ws2812b_rx_decoder_if;
    logic       din_raw;
    logic       bit_valid;
    logic       bit_value;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       idle;
    logic       glitch;
    logic [1:0] state_dbg;

    modport master (
        input  din_raw,
        output bit_valid, bit_value, byte_valid, byte_data, idle, glitch, state_dbg
    );

    modport slave (
        input din_raw, bit_valid, bit_value, byte_valid, byte_data, idle, glitch, state_dbg
    );
endinterface

// File: rtl/ws2812b_rx_decoder.sv
// ws2812b_rx_decoder
// Synchronises the WS2812B serial line, measures each high pulse to classify
// it as a 0 or 1 code, shifts bits MSB-first into bytes and reports the
// reset/latch gap as an idle event.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : ws2812b_rx_decoder_if.master (din_raw in, decoded events out)
// Optional feature: define WS2812B_GLITCH_FILTER_EN to drop high pulses
// shorter than MIN_PULSE cycles (reported on glitch). Without it every high
// pulse decodes as a bit and glitch is constant 0.
module ws2812b_rx_decoder #(
    parameter int BIT_THRESH  = 38,
    parameter int IDLE_CYCLES = 3200,
    parameter int MIN_PULSE   = 6,
    parameter int CNT_W       = 12
) (
    input logic                   clk,
    input logic                   reset,
    ws2812b_rx_decoder_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] IDLE_C    = CNT_W'(IDLE_CYCLES);

    state_t           state, state_n;
    logic             sync1, din_s, din_prev;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       sr, sr_n;
    logic             bit_valid_q, bit_valid_n;
    logic             bit_value_q, bit_value_n;
    logic             byte_valid_q, byte_valid_n;
    logic [7:0]       byte_data_q, byte_data_n;
    logic             idle_q, idle_n;
    logic             glitch_q, glitch_n;
    logic             rise, fall, bit_b, runt;

    assign rise    = din_s & ~din_prev;
    assign fall    = ~din_s & din_prev;
    // Saturate so a line stuck high still decodes as a long (1) pulse.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign bit_b   = (cnt >= THRESH_C);

`ifdef WS2812B_GLITCH_FILTER_EN
    assign runt = (cnt < CNT_W'(MIN_PULSE));
`else
    logic [CNT_W-1:0] unused_min_pulse;
    assign unused_min_pulse = CNT_W'(MIN_PULSE);
    assign runt = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= 1'b0;
            din_s        <= 1'b0;
            din_prev     <= 1'b0;
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sr           <= '0;
            bit_valid_q  <= 1'b0;
            bit_value_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            idle_q       <= 1'b0;
            glitch_q     <= 1'b0;
        end else begin
            sync1        <= bus.din_raw;
            din_s        <= sync1;
            din_prev     <= din_s;
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            sr           <= sr_n;
            bit_valid_q  <= bit_valid_n;
            bit_value_q  <= bit_value_n;
            byte_valid_q <= byte_valid_n;
            byte_data_q  <= byte_data_n;
            idle_q       <= idle_n;
            glitch_q     <= glitch_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_cnt_n    = bit_cnt;
        sr_n         = sr;
        bit_valid_n  = 1'b0;
        bit_value_n  = bit_value_q;
        byte_valid_n = 1'b0;
        byte_data_n  = byte_data_q;
        idle_n       = 1'b0;
        glitch_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    if (runt) begin
                        // Runt pulse: shift state untouched, idle timing restarts.
                        glitch_n = 1'b1;
                    end else begin
                        bit_valid_n = 1'b1;
                        bit_value_n = bit_b;
                        sr_n        = {sr[6:0], bit_b};
                        bit_cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_valid_n = 1'b1;
                            byte_data_n  = {sr[6:0], bit_b};
                        end
                    end
                    cnt_n   = CNT_ONE;
                    state_n = S_LOW;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_LOW: begin
                if (rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = S_HIGH;
                end else if (cnt == IDLE_C) begin
                    // Latch gap: any partial byte is discarded.
                    idle_n    = 1'b1;
                    bit_cnt_n = '0;
                    sr_n      = '0;
                    cnt_n     = '0;
                    state_n   = S_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_value  = bit_value_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.idle       = idle_q;
    assign bus.glitch     = glitch_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
module tb_ws2812b_rx_decoder;
  localparam int IDLE_CYCLES = 3200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ws2812b_rx_decoder_if bus ();

  ws2812b_rx_decoder #(
    .BIT_THRESH (38),
    .IDLE_CYCLES(IDLE_CYCLES),
    .MIN_PULSE  (6),
    .CNT_W      (12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_bits = 0;
  int n_bytes = 0;
  int n_idle = 0;
  int n_glitch = 0;
  int last_bv_cyc = 0;
  int idle_cyc = 0;
  logic [7:0] bit_hist = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.bit_valid) begin
        n_bits++;
        bit_hist = {bit_hist[6:0], bus.bit_value};
        last_bv_cyc = cyc;
      end
      if (bus.byte_valid) begin
        n_bytes++;
        chk("byte_with_bit", {31'd0, bus.bit_valid}, 32'd1);
        chk("byte_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) chk("byte_data", {24'd0, bus.byte_data}, {24'd0, exp_q.pop_front()});
      end
      if (bus.idle) begin
        n_idle++;
        idle_cyc = cyc;
      end
      if (bus.glitch) n_glitch++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pulse(input int h, input int l);
    @(negedge clk);
    bus.din_raw = 1'b1;
    repeat (h) @(negedge clk);
    bus.din_raw = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(51, 29);
    else   send_pulse(26, 54);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int b0, y0, i0, g0;

  initial begin
    bus.din_raw = 1'b0;
    wait_cycles(3);
    chk("rst_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    chk("rst_bit_value", {31'd0, bus.bit_value}, 32'd0);
    chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
    chk("rst_byte_data", {24'd0, bus.byte_data}, 32'd0);
    chk("rst_idle", {31'd0, bus.idle}, 32'd0);
    chk("rst_glitch", {31'd0, bus.glitch}, 32'd0);
    chk("rst_state", {30'd0, bus.state_dbg}, 32'd0);
    reset = 1'b0;

    // no idle out of reset alone
    wait_cycles(IDLE_CYCLES + 200);
    chk("no_idle_after_reset", n_idle, 0);

    // byte 0xA5
    b0 = n_bits; y0 = n_bytes;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    wait_cycles(10);
    chk("a5_bit_count", n_bits - b0, 8);
    chk("a5_bit_values", {24'd0, bit_hist}, 32'hA5);
    chk("a5_byte_count", n_bytes - y0, 1);
    chk("a5_byte_hold", {24'd0, bus.byte_data}, 32'hA5);

    // threshold boundary and saturation
    send_pulse(38, 42);
    wait_cycles(5);
    chk("thresh_38", {31'd0, bus.bit_value}, 32'd1);
    send_pulse(37, 43);
    wait_cycles(5);
    chk("thresh_37", {31'd0, bus.bit_value}, 32'd0);
    send_pulse(5000, 40);
    wait_cycles(5);
    chk("stuck_high_is_1", {31'd0, bus.bit_value}, 32'd1);
    i0 = n_idle;
    wait_cycles(IDLE_CYCLES + 100);
    chk("idle_after_partial", n_idle - i0, 1);

    // frame of 3 bytes then gap
    y0 = n_bytes; i0 = n_idle;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    wait_cycles(IDLE_CYCLES + 100);
    chk("frame_byte_count", n_bytes - y0, 3);
    chk("frame_idle_count", n_idle - i0, 1);
    chk("frame_idle_delay", idle_cyc - last_bv_cyc, IDLE_CYCLES);
    chk("frame_idle_state", {30'd0, bus.state_dbg}, 32'd0);

    // partial byte, gap, then 0xC3
    y0 = n_bytes;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    wait_cycles(IDLE_CYCLES + 100);
    chk("partial_no_byte", n_bytes - y0, 0);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    wait_cycles(10);
    chk("c3_byte_count", n_bytes - y0, 1);
    chk("c3_byte_data", {24'd0, bus.byte_data}, 32'hC3);

    // reset mid-byte
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    bus.din_raw = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_bit_value", {31'd0, bus.bit_value}, 32'd0);
    chk("mid_rst_byte_data", {24'd0, bus.byte_data}, 32'd0);
    chk("mid_rst_state", {30'd0, bus.state_dbg}, 32'd0);
    bus.din_raw = 1'b0;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(10);
    b0 = n_bits; y0 = n_bytes;
    exp_q.push_back(8'hFF);
    send_byte(8'hFF);
    wait_cycles(10);
    chk("ff_bit_count", n_bits - b0, 8);
    chk("ff_byte_count", n_bytes - y0, 1);
    chk("ff_byte_data", {24'd0, bus.byte_data}, 32'hFF);
    wait_cycles(IDLE_CYCLES + 100);

    // runt pulse inside 0x0F
    b0 = n_bits; y0 = n_bytes; g0 = n_glitch;
`ifdef WS2812B_GLITCH_FILTER_EN
    exp_q.push_back(8'h0F);
`else
    exp_q.push_back(8'h07);
`endif
    send_bit(1'b0); send_bit(1'b0);
    send_pulse(3, 40);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    wait_cycles(10);
`ifdef WS2812B_GLITCH_FILTER_EN
    chk("runt_bit_count", n_bits - b0, 8);
    chk("runt_glitch_count", n_glitch - g0, 1);
    chk("runt_byte_data", {24'd0, bus.byte_data}, 32'h0F);
`else
    chk("runt_bit_count", n_bits - b0, 9);
    chk("runt_glitch_count", n_glitch - g0, 0);
    chk("runt_byte_data", {24'd0, bus.byte_data}, 32'h07);
`endif
    chk("runt_byte_count", n_bytes - y0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
